// File: rtl/m_mem_arbiter.sv
// m_mem_arbiter: shares one single-ported memory between the fetch and data
// ports; data wins conflicts, bounded by a fetch starvation guard.
module m_mem_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_ireq,
  input  logic [ADDR_W-1:0] w_iaddr,
  output logic              w_igrant,
  output logic              r_ivalid,
  output logic [DATA_W-1:0] w_irdata,
  input  logic              w_dreq,
  input  logic              w_dwe,
  input  logic [ADDR_W-1:0] w_daddr,
  input  logic [DATA_W-1:0] w_ddin,
  output logic              w_dgrant,
  output logic              r_dvalid,
  output logic [DATA_W-1:0] w_drdata,
  output logic [ADDR_W-1:0] w_maddr,
  output logic              w_mwe,
  output logic [DATA_W-1:0] w_mdin,
  input  logic [DATA_W-1:0] w_mdout,
  output logic [15:0]       r_conflicts
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0] r_wait;
  logic [3:0] w_wait_nxt;
  logic       w_force;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_wait <= '0;
    end else begin
      r_wait <= w_wait_nxt;
    end
  end

  // Counts consecutive denied fetch cycles; any fetch grant or idle clears it.
  always_comb begin
    w_wait_nxt = '0;
    if (w_ireq && !w_igrant) begin
      if (r_wait == LP_MAX_WAIT) begin
        w_wait_nxt = r_wait;
      end else begin
        w_wait_nxt = r_wait + 4'd1;
      end
    end
  end

  always_comb begin
    w_force  = (r_wait == LP_MAX_WAIT);
    w_igrant = w_ireq && (!w_dreq || w_force);
    w_dgrant = w_dreq && !w_igrant;
    w_maddr  = w_dgrant ? w_daddr : w_iaddr;
    w_mwe    = w_dgrant && w_dwe && !w_rst;
    w_mdin   = w_ddin;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_ivalid <= 1'b0;
      r_dvalid <= 1'b0;
    end else begin
      r_ivalid <= w_igrant;
      r_dvalid <= w_dgrant && !w_dwe;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_conflicts <= '0;
    end else if (w_ireq && w_dreq && (r_conflicts != 16'hFFFF)) begin
      r_conflicts <= r_conflicts + 16'd1;
    end
  end

  assign w_irdata = w_mdout;
  assign w_drdata = w_mdout;

endmodule

// File: tb/tb_m_mem_arbiter.sv
// tb_m_mem_arbiter: scoreboard bench with a behavioural memory/arbiter model
// and random plus directed stimulus.
module tb_m_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int MW = 3;

  typedef struct {
    logic          ig;
    logic          dg;
    logic          mwe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mdin;
    logic [15:0]   conf;
  } exp_t;

  logic          w_clk = 1'b0;
  logic          w_rst;
  logic          w_ireq;
  logic [AW-1:0] w_iaddr;
  logic          w_igrant;
  logic          r_ivalid;
  logic [DW-1:0] w_irdata;
  logic          w_dreq;
  logic          w_dwe;
  logic [AW-1:0] w_daddr;
  logic [DW-1:0] w_ddin;
  logic          w_dgrant;
  logic          r_dvalid;
  logic [DW-1:0] w_drdata;
  logic [AW-1:0] w_maddr;
  logic          w_mwe;
  logic [DW-1:0] w_mdin;
  logic [DW-1:0] w_mdout;
  logic [15:0]   r_conflicts;

  m_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_ireq(w_ireq), .w_iaddr(w_iaddr), .w_igrant(w_igrant),
    .r_ivalid(r_ivalid), .w_irdata(w_irdata),
    .w_dreq(w_dreq), .w_dwe(w_dwe), .w_daddr(w_daddr), .w_ddin(w_ddin),
    .w_dgrant(w_dgrant), .r_dvalid(r_dvalid), .w_drdata(w_drdata),
    .w_maddr(w_maddr), .w_mwe(w_mwe), .w_mdin(w_mdin), .w_mdout(w_mdout),
    .r_conflicts(r_conflicts)
  );

  always #5 w_clk = ~w_clk;

  // Physical memory behind the arbiter: registered read, write at posedge.
  logic [DW-1:0] mem [2048];
  always @(posedge w_clk) begin
    if (w_mwe) mem[w_maddr] <= w_mdin;
    w_mdout <= mem[w_maddr];
  end

  logic [DW-1:0] ref_mem [2048];
  exp_t          gq[$];
  logic [DW-1:0] iq[$];
  logic [DW-1:0] dq[$];
  int            m_wait = 0;
  int            m_conf = 0;
  int            n_chk = 0;
  int            n_err = 0;
  logic          mon_on = 1'b0;
  exp_t          mon_e;

  function automatic logic [DW-1:0] ival(int i);
    if (i == 5) return 32'h20;
    return (32'(i) * 32'h0100_0193) ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic step(input logic ir, input logic [AW-1:0] ia,
                      input logic dr, input logic dw,
                      input logic [AW-1:0] da, input logic [DW-1:0] dd,
                      input logic rs, output logic ig, output logic dg);
    exp_t e;
    @(posedge w_clk);
    #1;
    w_rst = rs; w_ireq = ir; w_iaddr = ia;
    w_dreq = dr; w_dwe = dw; w_daddr = da; w_ddin = dd;
    ig = ir && (!dr || m_wait == MW);
    dg = dr && !ig;
    e.ig = ig; e.dg = dg;
    e.mwe = dg && dw && !rs;
    e.maddr = dg ? da : ia;
    e.mdin = dd;
    e.conf = 16'(m_conf);
    gq.push_back(e);
    if (!rs) begin
      if (ig) iq.push_back(ref_mem[ia]);
      if (dg && dw) ref_mem[da] = dd;
      else if (dg) dq.push_back(ref_mem[da]);
    end
    if (rs || !ir || ig) m_wait = 0;
    else if (m_wait < MW) m_wait++;
    if (rs) m_conf = 0;
    else if (ir && dr && m_conf < 65535) m_conf++;
  endtask

  always @(negedge w_clk) begin
    if (mon_on) begin
      if (gq.size() != 0) begin
        mon_e = gq.pop_front();
        chk("igrant", {31'd0, w_igrant}, {31'd0, mon_e.ig});
        chk("dgrant", {31'd0, w_dgrant}, {31'd0, mon_e.dg});
        chk("mwe", {31'd0, w_mwe}, {31'd0, mon_e.mwe});
        chk("conflicts", {16'd0, r_conflicts}, {16'd0, mon_e.conf});
        if (mon_e.ig || mon_e.dg)
          chk("maddr", {21'd0, w_maddr}, {21'd0, mon_e.maddr});
        if (mon_e.mwe) chk("mdin", w_mdin, mon_e.mdin);
      end
      if (r_ivalid !== 1'b0) begin
        chk("ivalid_known", {31'd0, r_ivalid}, 32'd1);
        if (iq.size() == 0) chk("ivalid_spurious", 32'd1, 32'd0);
        else chk("irdata", w_irdata, iq.pop_front());
      end
      if (r_dvalid !== 1'b0) begin
        chk("dvalid_known", {31'd0, r_dvalid}, 32'd1);
        if (dq.size() == 0) chk("dvalid_spurious", 32'd1, 32'd0);
        else chk("drdata", w_drdata, dq.pop_front());
      end
    end
  end

  initial begin
    logic ig, dg;
    logic ip, dp, dwp;
    logic [AW-1:0] ipa, dpa;
    logic [DW-1:0] dpd;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = ival(i);
      ref_mem[i] = ival(i);
    end
    w_rst = 1'b1; w_ireq = 1'b0; w_iaddr = '0;
    w_dreq = 1'b0; w_dwe = 1'b0; w_daddr = '0; w_ddin = '0;
    repeat (2) @(posedge w_clk);
    #1;
    w_rst = 1'b0;
    mon_on = 1'b1;

    // reset state, then fetch-only read of address 5
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    step(1, 5, 0, 0, 0, 0, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);

    // data write then read-back of the same address
    step(0, 0, 1, 1, 11'h10, 32'hDEADBEEF, 0, ig, dg);
    step(0, 0, 1, 0, 11'h10, 0, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);

    // sustained conflict from a clean reset
    step(0, 0, 0, 0, 0, 0, 1, ig, dg);
    for (int i = 0; i < 8; i++) step(1, 7, 1, 0, 9, 0, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);

    // reset while a data read is granted and fetch is partly starved
    step(1, 7, 1, 0, 9, 0, 0, ig, dg);
    step(1, 7, 1, 0, 9, 0, 0, ig, dg);
    step(1, 7, 1, 0, 3, 0, 1, ig, dg);
    for (int i = 0; i < 4; i++) step(1, 7, 1, 0, 9, 0, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);

    // write attempted during reset must not land
    step(0, 0, 1, 1, 11'h20, 32'h1234_5678, 1, ig, dg);
    step(0, 0, 1, 0, 11'h20, 0, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);

    // random traffic with held requests and occasional reset
    ip = 0; dp = 0; ipa = '0; dpa = '0; dwp = 0; dpd = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1; ipa = AW'($urandom_range(0, 15));
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; dpa = AW'($urandom_range(0, 15));
        dwp = 1'($urandom_range(0, 1)); dpd = $urandom;
      end
      step(ip, ipa, dp, dwp, dpa, dpd,
           1'($urandom_range(0, 199) == 0), ig, dg);
      if (ig) ip = 0;
      if (dg) dp = 0;
    end
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);

    // conflict counter saturation
    step(0, 0, 0, 0, 0, 0, 1, ig, dg);
    for (int i = 0; i < 65540; i++) step(1, 1, 1, 0, 2, 0, 0, ig, dg);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 2, 0, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    chk("conflicts_sat", {16'd0, r_conflicts}, 32'h0000_FFFF);

    repeat (2) @(negedge w_clk);
    #1;
    chk("ifetch_q_drained", iq.size(), 0);
    chk("data_q_drained", dq.size(), 0);
    chk("grant_q_drained", gq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
